// File: rtl/fifo_arb_pkg.sv
// Shared state type, width helpers and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int STALL_W = 16;

    function automatic int ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int cnt_width(input int burst_max);
        return (burst_max > 0) ? $clog2(burst_max + 1) : 1;
    endfunction

    // One-hot positions whose index has bit_pos set; builds a one-hot to index encoder.
    function automatic int enc_mask(input int bit_pos, input int num_req);
        int m;
        m = 0;
        for (int j = 0; j < num_req; j++) begin
            if (((j >> bit_pos) & 1) == 1) m = m | (1 << j);
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request searching upward from i_last+1, wrapping.
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_valid
);

    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

    // Slot k of the rotated view holds requester (i_last + 1 + k) mod NUM_REQ.
    logic [PTR_W-1:0]   w_slot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_hit;

    genvar k, j;
    generate
        for (k = 0; k < NUM_REQ; k++) begin : g_slot
            localparam logic [NUM_REQ-1:0] EARLIER = NUM_REQ'((1 << k) - 1);
            logic [PTR_W:0] w_sum;
            assign w_sum         = {1'b0, i_last} + (PTR_W + 1)'(k + 1);
            assign w_slot_idx[k] = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
            assign w_rot[k]      = i_req[w_slot_idx[k]];
            assign w_hit[k]      = w_rot[k] & ~|(w_rot & EARLIER);
        end

        for (j = 0; j < NUM_REQ; j++) begin : g_out
            logic [NUM_REQ-1:0] w_match;
            for (k = 0; k < NUM_REQ; k++) begin : g_match
                assign w_match[k] = (w_slot_idx[k] == PTR_W'(j));
            end
            assign o_pick[j] = |(w_hit & w_match);
        end
    endgenerate

    assign o_valid = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Optional FULL-stall counter on STALL_CNT: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
    input  logic                     FULL,
    output logic [NUM_REQ-1:0]       ACK,
    output logic [NUM_REQ-1:0]       GNT,
    output logic                     W_INC,
    output logic [WIDTH-1:0]         WR_DATA,
    output logic [STALL_W-1:0]       STALL_CNT
);

    localparam int               PTR_W    = ptr_width(NUM_REQ);
    localparam int               CNT_W    = cnt_width(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

    arb_state_e         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_slice [NUM_REQ];
    logic [NUM_REQ-1:0] w_pick;
    logic               w_pick_valid;
    logic [PTR_W-1:0]   w_pick_idx;
    logic [PTR_W-1:0]   w_ptr;
    logic               w_owner_req;
    logic               w_release;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_slice
            assign w_slice[g] = REQ_DATA[g*WIDTH +: WIDTH];
        end
        for (g = 0; g < PTR_W; g++) begin : g_enc
            localparam logic [NUM_REQ-1:0] MASK = NUM_REQ'(enc_mask(g, NUM_REQ));
            assign w_pick_idx[g] = |(w_pick & MASK);
        end
    endgenerate

    // While granted, re-arbitration starts after the current owner.
    assign w_ptr = (r_state == GRANT) ? r_owner : r_last;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req   (REQ),
        .i_last  (w_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    assign w_owner_req = |(REQ & r_gnt);
    assign W_INC       = (r_state == GRANT) & w_owner_req & ~FULL;
    assign ACK         = r_gnt & {NUM_REQ{W_INC}};
    assign WR_DATA     = W_INC ? w_slice[r_owner] : '0;
    assign GNT         = r_gnt;
    assign w_release   = (r_state == GRANT) & (~w_owner_req | (W_INC & (r_cnt == CNT_LAST)));

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register here samples pre-edge values.
        if (!RST) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= PTR_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= GRANT;
                        r_gnt   <= w_pick;
                        r_owner <= w_pick_idx;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last <= r_owner;
                        r_cnt  <= '0;
                        if (w_pick_valid) begin
                            r_gnt   <= w_pick;
                            r_owner <= w_pick_idx;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (W_INC) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STALL_W-1:0] r_stall;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_stall <= '0;
        end else if ((r_state == GRANT) && w_owner_req && FULL && (r_stall != '1)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign STALL_CNT = r_stall;
`else
    assign STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner cases and
// randomized traffic compared against a cycle-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 4;

`ifdef FIFO_WR_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] REQ_DATA;
    logic           FULL;
    logic [N-1:0]   ACK;
    logic [N-1:0]   GNT;
    logic           W_INC;
    logic [W-1:0]   WR_DATA;
    logic [15:0]    STALL_CNT;

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .WIDTH     (W),
        .BURST_MAX (B)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .FULL      (FULL),
        .ACK       (ACK),
        .GNT       (GNT),
        .W_INC     (W_INC),
        .WR_DATA   (WR_DATA),
        .STALL_CNT (STALL_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus held for the current cycle, and outputs sampled mid-cycle.
    logic         g_rst;
    logic [N-1:0] g_req;
    logic         g_full;
    logic [W-1:0] g_data [N];
    string        g_tag;

    logic [N-1:0] s_gnt;
    logic         s_winc;
    logic [N-1:0] s_ack;
    logic [W-1:0] s_data;
    logic [15:0]  s_stall;

    // Reference model: owner index (-1 = nobody), words taken this burst, last owner, stalls.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_words = 0;
    int m_stall = 0;

    function automatic logic bit_of(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int search_from(input int start, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (bit_of(v, (start + k) % N)) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_stall();
        return STATS ? 32'(m_stall) : 32'd0;
    endfunction

    task automatic model_outputs(output logic [N-1:0] e_gnt, output logic e_winc,
                                 output logic [N-1:0] e_ack, output logic [W-1:0] e_data);
        e_gnt  = (m_owner < 0) ? '0 : N'(1 << m_owner);
        e_winc = (m_owner >= 0) && bit_of(g_req, m_owner) && !g_full;
        e_ack  = e_winc ? e_gnt : '0;
        e_data = e_winc ? g_data[m_owner] : '0;
    endtask

    task automatic model_step();
        logic owner_req;
        if (!g_rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_words = 0;
            m_stall = 0;
        end else if (m_owner < 0) begin
            m_owner = search_from(m_last, g_req);
            m_words = 0;
        end else begin
            owner_req = bit_of(g_req, m_owner);
            if (owner_req && g_full && m_stall < 65535) m_stall++;
            if (owner_req && !g_full) m_words++;
            if (!owner_req || m_words == B) begin
                m_last  = m_owner;
                m_owner = search_from(m_last, g_req);
                m_words = 0;
            end
        end
    endtask

    // One clock: drive, sample and optionally compare against the model, then advance.
    task automatic cycle(input bit chk);
        logic [N-1:0] e_gnt, e_ack;
        logic         e_winc;
        logic [W-1:0] e_data;
        RST  = g_rst;
        REQ  = g_req;
        FULL = g_full;
        for (int i = 0; i < N; i++) REQ_DATA[i*W +: W] = g_data[i];
        #3;
        s_gnt   = GNT;
        s_winc  = W_INC;
        s_ack   = ACK;
        s_data  = WR_DATA;
        s_stall = STALL_CNT;
        model_outputs(e_gnt, e_winc, e_ack, e_data);
        if (chk) begin
            check({g_tag, "/model_gnt"},   32'(s_gnt),   32'(e_gnt));
            check({g_tag, "/model_winc"},  32'(s_winc),  32'(e_winc));
            check({g_tag, "/model_ack"},   32'(s_ack),   32'(e_ack));
            check({g_tag, "/model_data"},  32'(s_data),  32'(e_data));
            check({g_tag, "/model_stall"}, 32'(s_stall), exp_stall());
        end
        @(posedge CLK);
        model_step();
        for (int i = 0; i < N; i++) if (s_ack[i] === 1'b1) g_data[i] = g_data[i] + 8'd1;
        #1;
    endtask

    task automatic do_reset();
        g_rst  = 1'b0;
        g_req  = '0;
        g_full = 1'b0;
        cycle(1'b1);
        g_rst = 1'b1;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         full;
        logic [N-1:0] gnt;
        logic         winc;
        logic [N-1:0] ack;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d3;
        g_tag  = "init";
        g_rst  = 1'b0;
        g_req  = '0;
        g_full = 1'b0;
        for (int i = 0; i < N; i++) g_data[i] = '0;
        @(posedge CLK);
        #1;
        cycle(1'b0);

        // Single requester: grant after one cycle, eight back-to-back words, seamless re-grant.
        g_tag     = "tbl";
        g_data[0] = 8'h10;
        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[1]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
        for (int k = 0; k < 8; k++)
            tbl[2+k] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0001, 8'(8'h10 + k)};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 8'h00};
        tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00};
        for (int r = 0; r < 12; r++) begin
            g_rst  = tbl[r].rst;
            g_req  = tbl[r].req;
            g_full = tbl[r].full;
            cycle(1'b1);
            check($sformatf("tbl[%0d]/gnt", r),  32'(s_gnt),  32'(tbl[r].gnt));
            check($sformatf("tbl[%0d]/winc", r), 32'(s_winc), 32'(tbl[r].winc));
            check($sformatf("tbl[%0d]/ack", r),  32'(s_ack),  32'(tbl[r].ack));
            check($sformatf("tbl[%0d]/data", r), 32'(s_data), 32'(tbl[r].data));
        end

        // All four requesting: bursts of four in order 0,1,2,3,0 with no gap.
        g_tag = "rr";
        do_reset();
        for (int i = 0; i < N; i++) g_data[i] = 8'(8'h80 + 16 * i);
        g_req = 4'b1111;
        cycle(1'b1);
        check("rr/idle_gnt", 32'(s_gnt), 32'd0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1);
            check($sformatf("rr/ack%0d", k),  32'(s_ack),  32'(1 << ((k / 4) % 4)));
            check($sformatf("rr/winc%0d", k), 32'(s_winc), 32'd1);
        end

        // Back-pressure on owner 2 after two words.
        g_tag = "bp";
        do_reset();
        g_req = 4'b1100;
        cycle(1'b1);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1);
            check("bp/pre_ack", 32'(s_ack), 32'b0100);
        end
        g_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1);
            check("bp/stall_winc", 32'(s_winc), 32'd0);
            check("bp/stall_ack",  32'(s_ack),  32'd0);
            check("bp/stall_gnt",  32'(s_gnt),  32'b0100);
        end
        g_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1);
            check("bp/post_ack", 32'(s_ack), 32'b0100);
        end
        cycle(1'b1);
        check("bp/rotate_gnt", 32'(s_gnt), 32'b1000);
        check("bp/stall_cnt",  32'(s_stall), STATS ? 32'd5 : 32'd0);

        // Early release: owner 1 drops after one word, requester 3 takes over at that edge.
        g_tag = "early";
        do_reset();
        g_req = 4'b1010;
        cycle(1'b1);
        cycle(1'b1);
        check("early/first_ack", 32'(s_ack), 32'b0010);
        g_req = 4'b1000;
        cycle(1'b1);
        check("early/drop_winc", 32'(s_winc), 32'd0);
        d3 = g_data[3];
        cycle(1'b1);
        check("early/new_gnt", 32'(s_gnt),  32'b1000);
        check("early/new_ack", 32'(s_ack),  32'b1000);
        check("early/data",    32'(s_data), 32'(d3));

        // Reset in the middle of a burst.
        g_tag = "rstmid";
        do_reset();
        g_req = 4'b0001;
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        g_rst = 1'b0;
        cycle(1'b1);
        check("rstmid/winc_before", 32'(s_winc), 32'd1);
        g_rst = 1'b1;
        g_req = 4'b1010;
        cycle(1'b1);
        check("rstmid/gnt",  32'(s_gnt),  32'd0);
        check("rstmid/winc", 32'(s_winc), 32'd0);
        check("rstmid/ack",  32'(s_ack),  32'd0);
        cycle(1'b1);
        check("rstmid/first_gnt", 32'(s_gnt), 32'b0010);

        // Long FULL stall: counter must saturate, never wrap.
        g_tag = "sat";
        do_reset();
        g_req  = 4'b0100;
        g_full = 1'b1;
        cycle(1'b1);
        for (int k = 0; k < 70000; k++) cycle(1'b0);
        cycle(1'b1);
        check("sat/stall_cnt", 32'(s_stall), STATS ? 32'h0000FFFF : 32'd0);
        check("sat/gnt_held",  32'(s_gnt),   32'b0100);

        // Random traffic against the model; data only changes after ACK.
        g_tag  = "rand";
        do_reset();
        g_full = 1'b0;
        for (int c = 0; c < 600; c++) begin
            g_rst  = ($urandom_range(0, 199) != 0);
            g_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (g_req[i] && (s_ack[i] !== 1'b1)) begin
                    if ($urandom_range(0, 19) == 0) g_req[i] = 1'b0;
                end else begin
                    g_req[i] = ($urandom_range(0, 9) < 6);
                    if (g_req[i]) g_data[i] = 8'($urandom);
                end
            end
            cycle(1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
